// File: rtl/inv_lift_step_pkg.sv
// -----------------------------------------------------------------------------
// inv_lift_step_pkg
// Shared definitions for the inverse lifting step block:
//   - sample, sum and internal arithmetic widths
//   - bit positions inside the 3-bit flags word
//   - clamp bounds used by the saturating reduction
//   - stage-1 pipeline record and an operation decoder
// -----------------------------------------------------------------------------
package inv_lift_step_pkg;

  localparam int SAMPLE_W   = 9;   // external sample width
  localparam int SUM_W      = 10;  // left + right neighbour sum
  localparam int INTERNAL_W = 11;  // full-precision result before reduction
  localparam int FLAGS_W    = 3;

  // Bit positions inside flags_i.
  localparam int FLAG_EN     = 2;  // 0 = pass-through
  localparam int FLAG_STEP   = 1;  // 1 = undo predict, 0 = undo update
  localparam int FLAG_MIRROR = 0;  // 1 = right operand replaced by left

  // Representable range of a SAMPLE_W-bit signed result.
  localparam logic signed [INTERNAL_W-1:0] CLAMP_MAX = 11'sd255;
  localparam logic signed [INTERNAL_W-1:0] CLAMP_MIN = -11'sd256;

  typedef enum logic [1:0] {
    OP_PASS    = 2'd0,
    OP_PREDICT = 2'd1,
    OP_UPDATE  = 2'd2
  } op_e;

  // Operands captured by stage 1 on an accepted strobe.
  typedef struct packed {
    logic signed [SUM_W-1:0]    sum;
    logic signed [SAMPLE_W-1:0] sam;
    logic [FLAGS_W-1:0]         flags;
  } stage1_t;

  // The mirror bit only affects operand selection, so it plays no part here.
  function automatic op_e decode_op(input logic [FLAGS_W-1:0] flags);
    if (!flags[FLAG_EN])       return OP_PASS;
    else if (flags[FLAG_STEP]) return OP_PREDICT;
    else                       return OP_UPDATE;
  endfunction

endpackage

// File: rtl/inv_lift_step_if.sv
// -----------------------------------------------------------------------------
// inv_lift_step_if
// Operand/result bundle of the inverse lifting step.
//   flags_i   [2:0]  op select (enable / step / mirror)
//   update_i         one-cycle operand strobe
//   left_i    [8:0]  signed left neighbour
//   sam_i     [8:0]  signed coefficient being inverted
//   right_i   [8:0]  signed right neighbour
//   sat_clr_i        clear of the sticky saturation flag
//   res_o     [8:0]  signed reconstructed sample (held between updates)
//   update_o         one-cycle strobe marking a new res_o
//   sat_o            sticky saturation flag
// Modports: master drives operands (testbench / upstream), slave is the block.
// -----------------------------------------------------------------------------
interface inv_lift_step_if;
  import inv_lift_step_pkg::*;

  logic [FLAGS_W-1:0]         flags_i;
  logic                       update_i;
  logic signed [SAMPLE_W-1:0] left_i;
  logic signed [SAMPLE_W-1:0] sam_i;
  logic signed [SAMPLE_W-1:0] right_i;
  logic                       sat_clr_i;
  logic signed [SAMPLE_W-1:0] res_o;
  logic                       update_o;
  logic                       sat_o;

  modport master (
    output flags_i, update_i, left_i, sam_i, right_i, sat_clr_i,
    input  res_o, update_o, sat_o
  );

  modport slave (
    input  flags_i, update_i, left_i, sam_i, right_i, sat_clr_i,
    output res_o, update_o, sat_o
  );

endinterface

// File: rtl/inv_lift_sat.sv
// -----------------------------------------------------------------------------
// inv_lift_sat
// Reduces an 11-bit signed result to a 9-bit signed sample.
//   din  [10:0]  full-precision signed result
//   dout [8:0]   reduced signed sample
//   sat          1 when din lay outside the 9-bit range and was clamped
// Build option: INV_LIFT_SAT_EN defined -> clamp to [-256, 255];
//               undefined -> two's-complement wrap, sat always 0.
// Purely combinational.
// -----------------------------------------------------------------------------
module inv_lift_sat
  import inv_lift_step_pkg::*;
(
  input  logic signed [INTERNAL_W-1:0] din,
  output logic signed [SAMPLE_W-1:0]   dout,
  output logic                         sat
);

`ifdef INV_LIFT_SAT_EN
  // NOTE: every output of an always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    dout = din[SAMPLE_W-1:0];
    sat  = 1'b0;
    if (din > CLAMP_MAX) begin
      dout = CLAMP_MAX[SAMPLE_W-1:0];
      sat  = 1'b1;
    end else if (din < CLAMP_MIN) begin
      dout = CLAMP_MIN[SAMPLE_W-1:0];
      sat  = 1'b1;
    end
  end
`else
  // Wrap build: the top bits are simply dropped.
  logic [INTERNAL_W-SAMPLE_W-1:0] din_high_unused;

  assign din_high_unused = din[INTERNAL_W-1:SAMPLE_W];
  assign dout            = din[SAMPLE_W-1:0];
  assign sat             = 1'b0;
`endif

endmodule

// File: rtl/inv_lift_step.sv
// -----------------------------------------------------------------------------
// inv_lift_step
// One inverse lifting step of a 9-bit integer wavelet, two pipeline stages.
//   clk_i    single clock, rising edge
//   rst_n_i  asynchronous active-low reset, clears every register
//   bus      inv_lift_step_if.slave (operands in, result/strobe/sat out)
// Operations (flags_i):
//   [2]=0        res = sam
//   [2]=1,[1]=1  res = sam + (sum >>> 1)          undo predict
//   [2]=1,[1]=0  res = sam - ((sum + 2) >>> 2)    undo update
//   sum = left + (flags[0] ? left : right)
// Stage 1 captures sum/sam/flags on update_i; stage 2 computes at 11 bits,
// reduces to 9 bits in inv_lift_sat and registers res_o / update_o.
// update_o follows an accepted update_i by exactly two cycles; strobes may
// arrive every cycle.
// Build option: INV_LIFT_SAT_EN -> saturate and drive a sticky sat_o;
// otherwise results wrap and sat_o is tied low.
// -----------------------------------------------------------------------------
module inv_lift_step
  import inv_lift_step_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_n_i,
  inv_lift_step_if.slave bus
);

  // ---------------------------------------------------------------------------
  // Stage 1: operand select and neighbour sum
  // ---------------------------------------------------------------------------
  logic signed [SAMPLE_W-1:0] right_sel;
  logic signed [SUM_W-1:0]    sum_next;
  stage1_t                    s1_q;
  logic                       s1_valid_q;

  assign right_sel = bus.flags_i[FLAG_MIRROR] ? bus.left_i : bus.right_i;
  // Both operands are sign-extended so the 10-bit sum cannot overflow.
  assign sum_next  = SUM_W'(bus.left_i) + SUM_W'(right_sel);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= bus.update_i;
      // Data inputs are only looked at on strobe cycles.
      if (bus.update_i) begin
        s1_q.sum   <= sum_next;
        s1_q.sam   <= bus.sam_i;
        s1_q.flags <= bus.flags_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: full-precision arithmetic, reduction, output registers
  // ---------------------------------------------------------------------------
  op_e                          op;
  logic signed [INTERNAL_W-1:0] sam_ext;
  logic signed [INTERNAL_W-1:0] sum_ext;
  logic signed [INTERNAL_W-1:0] sum_rnd;
  logic signed [INTERNAL_W-1:0] full_res;
  logic signed [SAMPLE_W-1:0]   reduced;
  logic                         sat_hit;

  assign op      = decode_op(s1_q.flags);
  assign sam_ext = INTERNAL_W'(s1_q.sam);
  assign sum_ext = INTERNAL_W'(s1_q.sum);
  // Rounding offset for the update step; 11 bits hold sum + 2 without loss.
  assign sum_rnd = sum_ext + 11'sd2;

  always_comb begin
    full_res = sam_ext;
    unique case (op)
      OP_PREDICT: full_res = sam_ext + (sum_ext >>> 1);
      OP_UPDATE:  full_res = sam_ext - (sum_rnd >>> 2);
      default:    full_res = sam_ext;
    endcase
  end

  // A pass-through value is a sign-extended 9-bit sample, so it can never
  // trip the clamp.
  inv_lift_sat u_sat (
    .din  (full_res),
    .dout (reduced),
    .sat  (sat_hit)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bus.res_o    <= '0;
      bus.update_o <= 1'b0;
    end else begin
      bus.update_o <= s1_valid_q;
      if (s1_valid_q) begin
        bus.res_o <= reduced;
      end
    end
  end

`ifdef INV_LIFT_SAT_EN
  // Sticky flag: a new saturation event outranks a clear in the same cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bus.sat_o <= 1'b0;
    end else if (s1_valid_q && sat_hit) begin
      bus.sat_o <= 1'b1;
    end else if (bus.sat_clr_i) begin
      bus.sat_o <= 1'b0;
    end
  end
`else
  logic sat_clr_unused;
  logic sat_hit_unused;

  assign sat_clr_unused = bus.sat_clr_i;
  assign sat_hit_unused = sat_hit;
  assign bus.sat_o      = 1'b0;
`endif

endmodule

// File: tb/tb_inv_lift_step.sv
// -----------------------------------------------------------------------------
// tb_inv_lift_step
// Directed testbench for inv_lift_step. Inputs change 1 time unit after a
// rising edge and outputs are sampled at the same point, away from the edge.
// Expected results are hand-computed; saturation-dependent expectations follow
// the INV_LIFT_SAT_EN build option.
// -----------------------------------------------------------------------------
module tb_inv_lift_step;
  import inv_lift_step_pkg::*;

  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  inv_lift_step_if bus ();

  inv_lift_step dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus.slave)
  );

  always #5 clk_i = ~clk_i;

`ifdef INV_LIFT_SAT_EN
  localparam logic [8:0] SAT_RES  = 9'd255;
  localparam logic       SAT_FLAG = 1'b1;
`else
  localparam logic [8:0] SAT_RES  = 9'h1FE;  // 510 wrapped to -2
  localparam logic       SAT_FLAG = 1'b0;
`endif

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one strobe; returns 1 time unit after the edge that samples it.
  task automatic send(input logic [2:0] f, input logic signed [8:0] l,
                      input logic signed [8:0] s, input logic signed [8:0] r);
    bus.flags_i  = f;
    bus.left_i   = l;
    bus.sam_i    = s;
    bus.right_i  = r;
    bus.update_i = 1'b1;
    tick();
    bus.update_i = 1'b0;
  endtask

  // Called right after send(): result appears exactly two edges after sampling.
  task automatic expect_result(input string tag, input logic [8:0] exp);
    check({tag, "_early"}, {8'd0, bus.update_o}, 9'd0);
    tick();
    check({tag, "_strobe"}, {8'd0, bus.update_o}, 9'd1);
    check({tag, "_res"}, bus.res_o, exp);
    tick();
    check({tag, "_strobe_end"}, {8'd0, bus.update_o}, 9'd0);
    check({tag, "_held"}, bus.res_o, exp);
  endtask

  initial begin
    bus.flags_i   = '0;
    bus.update_i  = 1'b0;
    bus.left_i    = '0;
    bus.sam_i     = '0;
    bus.right_i   = '0;
    bus.sat_clr_i = 1'b0;

    // Reset state.
    #1;
    check("rst_res", bus.res_o, 9'd0);
    check("rst_upd", {8'd0, bus.update_o}, 9'd0);
    check("rst_sat", {8'd0, bus.sat_o}, 9'd0);
    tick();
    tick();
    rst_n_i = 1'b1;

    // Undo predict: 103 + (231 >>> 1) = 218.
    send(3'd6, 9'sd68, 9'sd103, 9'sd163);
    expect_result("predict", 9'd218);

    // Undo update: 250 - ((324 + 2) >>> 2) = 169.
    send(3'd4, 9'sd164, 9'sd250, 9'sd160);
    expect_result("update", 9'd169);

    // Mirror: right ignored, 5 + (20 >>> 1) = 15.
    send(3'd7, 9'sd10, 9'sd5, 9'sd99);
    expect_result("mirror", 9'd15);

    // Floor shift: 0 + (-3 >>> 1) = -2.
    send(3'd6, -9'sd3, 9'sd0, 9'sd0);
    expect_result("floor", 9'h1FE);

    // Negative rounding: -10 - ((-9 + 2) >>> 2) = -10 - (-2) = -8.
    send(3'd4, -9'sd4, -9'sd10, -9'sd5);
    expect_result("upd_neg", 9'h1F8);

    // Pass-through ignores step/mirror and never saturates.
    send(3'd3, 9'sd255, -9'sd256, 9'sd255);
    expect_result("pass", 9'h100);
    check("pass_nosat", {8'd0, bus.sat_o}, 9'd0);

    // Data inputs are ignored without a strobe.
    bus.flags_i = 3'd6;
    bus.left_i  = 9'sd100;
    bus.sam_i   = 9'sd100;
    bus.right_i = 9'sd100;
    tick();
    tick();
    tick();
    check("idle_res", bus.res_o, 9'h100);
    check("idle_upd", {8'd0, bus.update_o}, 9'd0);

    // Overflow: 255 + 255 = 510 -> clamp to 255 or wrap to -2.
    send(3'd6, 9'sd255, 9'sd255, 9'sd255);
    expect_result("ovf", SAT_RES);
    check("ovf_sat", {8'd0, bus.sat_o}, {8'd0, SAT_FLAG});
    tick();
    check("sat_sticky", {8'd0, bus.sat_o}, {8'd0, SAT_FLAG});
    bus.sat_clr_i = 1'b1;
    tick();
    bus.sat_clr_i = 1'b0;
    check("sat_clr", {8'd0, bus.sat_o}, 9'd0);

    // Clear coinciding with a new saturation event: set wins.
    send(3'd6, 9'sd255, 9'sd255, 9'sd255);
    bus.sat_clr_i = 1'b1;
    tick();
    bus.sat_clr_i = 1'b0;
    check("setwins_upd", {8'd0, bus.update_o}, 9'd1);
    check("setwins_sat", {8'd0, bus.sat_o}, {8'd0, SAT_FLAG});
    bus.sat_clr_i = 1'b1;
    tick();
    bus.sat_clr_i = 1'b0;
    check("setwins_clr", {8'd0, bus.sat_o}, 9'd0);

    // Three back-to-back strobes: 169, 218, -7 in order.
    bus.flags_i = 3'd4; bus.left_i = 9'sd164; bus.sam_i = 9'sd250; bus.right_i = 9'sd160;
    bus.update_i = 1'b1;
    tick();
    check("b2b_gap", {8'd0, bus.update_o}, 9'd0);
    bus.flags_i = 3'd6; bus.left_i = 9'sd68; bus.sam_i = 9'sd103; bus.right_i = 9'sd163;
    tick();
    check("b2b_upd0", {8'd0, bus.update_o}, 9'd1);
    check("b2b_res0", bus.res_o, 9'd169);
    bus.flags_i = 3'd0; bus.left_i = 9'sd1; bus.sam_i = -9'sd7; bus.right_i = 9'sd1;
    tick();
    bus.update_i = 1'b0;
    check("b2b_upd1", {8'd0, bus.update_o}, 9'd1);
    check("b2b_res1", bus.res_o, 9'd218);
    tick();
    check("b2b_upd2", {8'd0, bus.update_o}, 9'd1);
    check("b2b_res2", bus.res_o, 9'h1F9);
    tick();
    check("b2b_end", {8'd0, bus.update_o}, 9'd0);
    check("b2b_held", bus.res_o, 9'h1F9);

    // Reset one cycle after a strobe: outputs clear at once, strobe dropped.
    send(3'd6, 9'sd68, 9'sd103, 9'sd163);
    rst_n_i = 1'b0;
    #1;
    check("arst_res", bus.res_o, 9'd0);
    check("arst_upd", {8'd0, bus.update_o}, 9'd0);
    check("arst_sat", {8'd0, bus.sat_o}, 9'd0);
    tick();
    rst_n_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("arst_nopulse", {8'd0, bus.update_o}, 9'd0);
    end

    // First strobe after release processes normally.
    send(3'd4, 9'sd164, 9'sd250, 9'sd160);
    expect_result("post_rst", 9'd169);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_lift_step.md
INV_LIFT_STEP -- requirements
Module: inv_lift_step

Interface
REQ-001 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-002 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port flags_i  input  3  op select: [2] enable (0 = pass-through), [1] step (1 = undo predict, 0 = undo update), [0] mirror (1 = right operand replaced by left_i).
REQ-004 SHALL have port update_i  input  1  one-cycle strobe; operands sampled on the edge where it is 1.
REQ-005 SHALL have port left_i  input  9  signed neighbour sample.
REQ-006 SHALL have port sam_i  input  9  signed coefficient being inverted.
REQ-007 SHALL have port right_i  input  9  signed neighbour sample.
REQ-008 SHALL have port sat_clr_i  input  1  synchronous clear of sat_o.
REQ-009 SHALL have port res_o  output  9  signed reconstructed sample, held between updates.
REQ-010 SHALL have port update_o  output  1  one-cycle strobe marking new res_o.
REQ-011 SHALL have port sat_o  output  1  sticky saturation flag.

Function
REQ-012 SHALL use a 2-stage pipeline: stage 1 registers sum = left + R (10-bit signed, R = left_i if flags_i[0] else right_i), sam_i and flags_i; stage 2 computes and registers res_o.
REQ-013 SHALL assert update_o exactly 2 cycles after each accepted update_i, for exactly 1 cycle.
REQ-014 SHALL accept update_i on consecutive cycles with no stall; each strobe yields its own update_o in order.
REQ-015 SHALL ignore all data inputs on cycles with update_i = 0; res_o holds its last value.
REQ-016 Undo predict (flags 1x1x, i.e. [2]=1,[1]=1) SHALL give sam + (sum >>> 1), arithmetic shift (floor toward -inf).
REQ-017 Undo update ([2]=1,[1]=0) SHALL give sam - ((sum + 2) >>> 2).
REQ-018 Pass-through ([2]=0) SHALL give res_o = sam_i regardless of [1:0].
REQ-019 SHALL evaluate arithmetic at 11-bit signed before reduction to 9 bits per REQ-027/028.
REQ-020 sat_clr_i and a new saturation event in the same cycle SHALL leave sat_o = 1 (set wins).

Reset
REQ-021 On rst_n_i = 0, res_o, update_o, sat_o and all pipeline registers including stage valid SHALL clear to 0 immediately.
REQ-022 Strobes in flight when reset asserts SHALL be discarded; no update_o after release for them.
REQ-023 First update_i sampled on the first rising edge after release SHALL be processed normally.

Configuration
REQ-024 Macro INV_LIFT_SAT_EN SHALL select the 11-to-9-bit reduction.
REQ-025 Defined: results clamp to [-256, 255]; any clamp sets sat_o.
REQ-026 Undefined: results wrap (two's-complement truncation); sat_o tied 0, sat_clr_i ignored.
REQ-027 Clamping SHALL occur only in stage 2; latency unchanged in both builds.
REQ-028 Pass-through results never saturate.

Structure
REQ-029 Shared package SHALL hold flag bit positions, sample width (9), internal width (11), clamp bounds.
REQ-030 Clamp/wrap logic SHALL be sub-module inv_lift_sat (11-bit in, 9-bit out, sat flag out), instanced once.

Verification
REQ-031 flags=6, left=68, right=163, sam=103, update pulse -> res_o=218, update_o 2 cycles later.
REQ-032 flags=4, left=164, right=160, sam=250 -> res_o=169.
REQ-033 flags=7, left=10, right=99, sam=5 -> res_o=15 (right ignored); flags=6, left=-3, right=0, sam=0 -> res_o=-2.
REQ-034 flags=6, left=right=sam=255 -> with INV_LIFT_SAT_EN res_o=255, sat_o=1 until sat_clr_i; without, res_o=-2, sat_o=0.
REQ-035 Three back-to-back strobes (flags 4, 6, 0) -> three consecutive update_o pulses with results in input order.
REQ-036 rst_n_i low 1 cycle after update_i -> outputs 0 at once, no update_o after release; next strobe processed normally.
